// File: rtl/issue_unit_pkg.sv
// Shared types and constants for the issue unit: functional-unit ids and the
// grant vector that carries one issue pulse per unit.
package issue_unit_pkg;

    localparam int NUM_UNITS = 4;

    typedef logic [1:0]           unit_id_t;
    typedef logic [NUM_UNITS-1:0] grant_vec_t;

    localparam unit_id_t UNIT_INT = 2'd0;
    localparam unit_id_t UNIT_MUL = 2'd1;
    localparam unit_id_t UNIT_DIV = 2'd2;
    localparam unit_id_t UNIT_MEM = 2'd3;

endpackage

// File: rtl/issue_unit_if.sv
// Issue-side bundle: queue-head readiness in, one-hot grant, divider and CDB
// status, and the statistics counters out.
interface issue_unit_if;
    import issue_unit_pkg::*;

    logic       rdy_int;
    logic       rdy_mul;
    logic       rdy_div;
    logic       rdy_mem;
    logic       mem_is_store;
    logic       mem_busy;
    grant_vec_t grant;
    logic       div_busy;
    logic       cdb_owner_valid;
    unit_id_t   cdb_owner;
    logic [31:0] stat_issue_cnt;
    logic [31:0] stat_stall_cnt;

    // Queue side drives readiness and observes the issue decision.
    modport master (
        output rdy_int, rdy_mul, rdy_div, rdy_mem, mem_is_store, mem_busy,
        input  grant, div_busy, cdb_owner_valid, cdb_owner,
               stat_issue_cnt, stat_stall_cnt
    );

    modport slave (
        input  rdy_int, rdy_mul, rdy_div, rdy_mem, mem_is_store, mem_busy,
        output grant, div_busy, cdb_owner_valid, cdb_owner,
               stat_issue_cnt, stat_stall_cnt
    );

endinterface

// File: rtl/issue_unit_cdb_reservation.sv
// cdb_reservation: CDB slot claims and their owner ids, shifting one slot per
// cycle. Slot j describes the bus j cycles from now; slot 0 is this cycle.
module cdb_reservation
    import issue_unit_pkg::*;
#(
    parameter  int CDB_WIN = 8,
    localparam int LAT_W   = $clog2(CDB_WIN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_claim_valid,
    input  logic [LAT_W-1:0] i_claim_lat,
    input  unit_id_t         i_claim_id,
    output logic [CDB_WIN:0] o_slots,
    output logic             o_head_valid,
    output unit_id_t         o_head_owner
);

    logic [CDB_WIN:0] r_s;
    logic [CDB_WIN:0] w_s_next;
    unit_id_t         r_o      [CDB_WIN+1];
    unit_id_t         w_o_next [CDB_WIN+1];

    // NOTE: every combinational output gets a default before any conditional
    // write, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_s_next = '0;
        for (int j = 0; j <= CDB_WIN; j++) begin
            w_o_next[j] = UNIT_INT;
        end
        for (int j = 0; j < CDB_WIN; j++) begin
            w_s_next[j] = r_s[j+1];
            w_o_next[j] = r_o[j+1];
            if (i_claim_valid && i_claim_lat == LAT_W'(j + 1)) begin
                w_s_next[j] = 1'b1;
                w_o_next[j] = i_claim_id;
            end
        end
    end

    // NOTE: the owner array is reset along with the claim bits: it is only a
    // few flops, and a flushed pipeline must not leave stale ids behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s <= '0;
            for (int j = 0; j <= CDB_WIN; j++) begin
                r_o[j] <= UNIT_INT;
            end
        end else begin
            // NOTE: non-blocking so every slot samples its neighbour's old value.
            r_s <= w_s_next;
            for (int j = 0; j <= CDB_WIN; j++) begin
                r_o[j] <= w_o_next[j];
            end
        end
    end

    assign o_slots      = r_s;
    assign o_head_valid = r_s[0];
    assign o_head_owner = r_s[0] ? r_o[0] : UNIT_INT;

endmodule

// File: rtl/issue_unit.sv
// issue_unit: round-robin issue arbiter with CDB slot reservation and a
// non-pipelined divider. Define ISSUE_UNIT_STATS_EN to build the grant/stall counters.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int INT_LAT = 1,
    parameter int MEM_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 7,
    parameter int CDB_WIN = 8
) (
    input  logic         clk,
    input  logic         reset,
    issue_unit_if.slave  io_iss
);

    localparam int LAT_W = $clog2(CDB_WIN + 1);
    localparam int DIV_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    logic [CDB_WIN:0] w_slots;
    logic             w_head_valid;
    unit_id_t         w_head_owner;
    grant_vec_t       w_elig;
    grant_vec_t       w_grant;
    unit_id_t         w_gnt_id;
    logic             w_gnt_valid;
    logic             w_claim_valid;
    logic [LAT_W-1:0] w_claim_lat;
    logic             w_div_busy;
    unit_id_t         r_rr;
    logic [DIV_W-1:0] r_div_cnt;

    function automatic logic slot_taken(input logic [CDB_WIN:0] slots, input int lat);
        return slots[lat];
    endfunction

    function automatic logic [LAT_W-1:0] unit_lat(input unit_id_t id);
        case (id)
            UNIT_INT: return LAT_W'(INT_LAT);
            UNIT_MUL: return LAT_W'(MUL_LAT);
            UNIT_DIV: return LAT_W'(DIV_LAT);
            default:  return LAT_W'(MEM_LAT);
        endcase
    endfunction

    assign w_div_busy = (r_div_cnt != '0);

    // A store never writes the CDB, so it ignores the slot it would have used.
    always_comb begin
        w_elig           = '0;
        w_elig[UNIT_INT] = io_iss.rdy_int && !slot_taken(w_slots, INT_LAT);
        w_elig[UNIT_MUL] = io_iss.rdy_mul && !slot_taken(w_slots, MUL_LAT);
        w_elig[UNIT_DIV] = io_iss.rdy_div && !slot_taken(w_slots, DIV_LAT) && !w_div_busy;
        w_elig[UNIT_MEM] = io_iss.rdy_mem && !io_iss.mem_busy &&
                           (io_iss.mem_is_store || !slot_taken(w_slots, MEM_LAT));
    end

    always_comb begin
        w_grant     = '0;
        w_gnt_id    = UNIT_INT;
        w_gnt_valid = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_id_t idx;
            idx = r_rr + unit_id_t'(i);
            if (!w_gnt_valid && w_elig[idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = idx;
            end
        end
        if (w_gnt_valid) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    assign w_claim_valid = w_gnt_valid && !(w_gnt_id == UNIT_MEM && io_iss.mem_is_store);
    assign w_claim_lat   = unit_lat(w_gnt_id);

    cdb_reservation #(
        .CDB_WIN (CDB_WIN)
    ) u_cdb_reservation (
        .clk           (clk),
        .reset         (reset),
        .i_claim_valid (w_claim_valid),
        .i_claim_lat   (w_claim_lat),
        .i_claim_id    (w_gnt_id),
        .o_slots       (w_slots),
        .o_head_valid  (w_head_valid),
        .o_head_owner  (w_head_owner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr      <= UNIT_INT;
            r_div_cnt <= '0;
        end else begin
            if (w_gnt_valid) begin
                r_rr <= w_gnt_id + unit_id_t'(1);
            end
            if (w_grant[UNIT_DIV]) begin
                r_div_cnt <= DIV_W'(DIV_LAT - 1);
            end else if (w_div_busy) begin
                r_div_cnt <= r_div_cnt - 1'b1;
            end
        end
    end

`ifdef ISSUE_UNIT_STATS_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_any_rdy;

    assign w_any_rdy = io_iss.rdy_int || io_iss.rdy_mul || io_iss.rdy_div || io_iss.rdy_mem;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_gnt_valid && r_issue_cnt != '1) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (w_any_rdy && !w_gnt_valid && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign io_iss.stat_issue_cnt = r_issue_cnt;
    assign io_iss.stat_stall_cnt = r_stall_cnt;
`else
    assign io_iss.stat_issue_cnt = '0;
    assign io_iss.stat_stall_cnt = '0;
`endif

    assign io_iss.grant           = w_grant;
    assign io_iss.div_busy        = w_div_busy;
    assign io_iss.cdb_owner_valid = w_head_valid;
    assign io_iss.cdb_owner       = w_head_owner;

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios then random traffic,
// compared against a model that books CDB cycles by absolute cycle number.
module tb_issue_unit;
    import issue_unit_pkg::*;

    localparam int INT_LAT = 1;
    localparam int MEM_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 7;
    localparam int CDB_WIN = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    issue_unit_if bus ();

    issue_unit #(
        .INT_LAT (INT_LAT),
        .MEM_LAT (MEM_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CDB_WIN (CDB_WIN)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_iss (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: absolute cycle -> unit owning the CDB in that cycle.
    int          cyc      = 0;
    int          rr_m     = 0;
    int          div_free = 0;
    bit [1:0]    book [int];
    int unsigned m_issue  = 0;
    int unsigned m_stall  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int u);
        case (u)
            UNIT_INT: return INT_LAT;
            UNIT_MUL: return MUL_LAT;
            UNIT_DIV: return DIV_LAT;
            default:  return MEM_LAT;
        endcase
    endfunction

    function automatic bit eligible(input int u, input bit [3:0] rdy, input bit store, input bit mbusy);
        if (!rdy[u]) return 1'b0;
        if (u == UNIT_DIV && cyc < div_free) return 1'b0;
        if (u == UNIT_MEM && mbusy) return 1'b0;
        if (u == UNIT_MEM && store) return 1'b1;
        return !book.exists(cyc + lat_of(u));
    endfunction

    function automatic int pick(input bit [3:0] rdy, input bit store, input bit mbusy);
        for (int k = 0; k < 4; k++) begin
            if (eligible((rr_m + k) % 4, rdy, store, mbusy)) return (rr_m + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_stats(input string tag);
`ifdef ISSUE_UNIT_STATS_EN
        check({tag, "_issue_cnt"}, bus.stat_issue_cnt, m_issue);
        check({tag, "_stall_cnt"}, bus.stat_stall_cnt, m_stall);
`else
        check({tag, "_issue_cnt"}, bus.stat_issue_cnt, 32'd0);
        check({tag, "_stall_cnt"}, bus.stat_stall_cnt, 32'd0);
`endif
    endtask

    task automatic drive(input bit [3:0] rdy, input bit store, input bit mbusy);
        bus.rdy_int      = rdy[0];
        bus.rdy_mul      = rdy[1];
        bus.rdy_div      = rdy[2];
        bus.rdy_mem      = rdy[3];
        bus.mem_is_store = store;
        bus.mem_busy     = mbusy;
    endtask

    // One clock cycle: entered and left at posedge+1. exp_g < 0 means no directed value.
    task automatic step(input bit [3:0] rdy, input bit store, input bit mbusy, input int exp_g);
        int       g;
        int       own;
        bit       vld;
        drive(rdy, store, mbusy);
        #1;
        g   = pick(rdy, store, mbusy);
        vld = book.exists(cyc);
        own = vld ? int'(book[cyc]) : 0;
        check("grant", bus.grant, (g < 0) ? 0 : (1 << g));
        if (exp_g >= 0) check("grant_directed", bus.grant, exp_g);
        check("div_busy", bus.div_busy, cyc < div_free);
        check("cdb_owner_valid", bus.cdb_owner_valid, vld);
        check("cdb_owner", bus.cdb_owner, own);
        check_stats("step");
        @(posedge clk);
        if (g >= 0) begin
            m_issue++;
            rr_m = (g + 1) % 4;
            if (!(g == UNIT_MEM && store)) book[cyc + lat_of(g)] = 2'(g);
            if (g == UNIT_DIV) div_free = cyc + DIV_LAT;
        end else if (rdy != 4'b0) begin
            m_stall++;
        end
        if (vld) book.delete(cyc);
        cyc++;
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; effects are checked before any clock edge.
    task automatic reset_mid();
        #2;
        reset = 1'b1;
        #1;
        book.delete();
        rr_m     = 0;
        div_free = 0;
        m_issue  = 0;
        m_stall  = 0;
        check("rst_cdb_owner_valid", bus.cdb_owner_valid, 1'b0);
        check("rst_div_busy", bus.div_busy, 1'b0);
        check_stats("rst");
        drive(4'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        drive(4'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("init_cdb_owner_valid", bus.cdb_owner_valid, 1'b0);
        check("init_div_busy", bus.div_busy, 1'b0);
        check_stats("init");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;

        // All ready with loads: int, mul, div, then int because mem's cycle-5 slot is the mul's.
        step(4'b1111, 1'b0, 1'b0, 1);
        step(4'b1111, 1'b0, 1'b0, 2);
        step(4'b1111, 1'b0, 1'b0, 4);
        step(4'b1111, 1'b0, 1'b0, 1);
        // Pointer now at mul.
        step(4'b1111, 1'b0, 1'b0, 2);
        repeat (6) step(4'b0000, 1'b0, 1'b0, 0);

        // Same sequence with a store at cycle 3: mem is granted and books nothing.
        reset_mid();
        step(4'b1111, 1'b0, 1'b0, 1);
        step(4'b1111, 1'b0, 1'b0, 2);
        step(4'b1111, 1'b0, 1'b0, 4);
        step(4'b1111, 1'b1, 1'b0, 8);
        step(4'b0000, 1'b0, 1'b0, 0);
        step(4'b0000, 1'b0, 1'b0, 0);

        // Reset while the divider is busy and claims are pending; the divider is free at once.
        reset_mid();
        step(4'b0100, 1'b0, 1'b0, 4);
        for (int i = 1; i <= 6; i++) step(4'b0100, 1'b0, 1'b0, 0);
        step(4'b0100, 1'b0, 1'b0, 4);
        repeat (3) step(4'b0000, 1'b0, 1'b0, 0);

        // Ten grants followed by three stalled cycles.
        reset_mid();
        repeat (10) step(4'b0001, 1'b0, 1'b0, 1);
        repeat (3) step(4'b1000, 1'b0, 1'b1, 0);
`ifdef ISSUE_UNIT_STATS_EN
        check("stats_issue_total", bus.stat_issue_cnt, 32'd10);
        check("stats_stall_total", bus.stat_stall_cnt, 32'd3);
`else
        check("stats_issue_total", bus.stat_issue_cnt, 32'd0);
        check("stats_stall_total", bus.stat_stall_cnt, 32'd0);
`endif

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_mid();
            end else begin
                step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
